// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC and drives the instruction memory address.
// Each word read back is captured in a small prefetch FIFO, and decode drains
// the FIFO in order through a valid/ready handshake. A redirect flushes the
// FIFO and restarts fetch at the new target.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [10:0]             imem_a,
    input  logic [31:0]             imem_rd,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    input  logic                    instr_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];

    // Handshake qualifiers: pop whenever decode takes a valid head; push only
    // in RUN, never during a redirect, and only if a slot is free (or frees up).
    always_comb begin
        pop  = (count_q != '0) & instr_ready;
        push = (state_q == RUN) & ~redirect & ((count_q < CW'(DEPTH)) | pop);
    end

    // Next-state logic; redirect overrides all pointer, count and PC updates.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (push) begin
            tail_d = tail_q + AW'(1);
            fpc_d  = fpc_q + 32'd4;
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end

        if (redirect) begin
            fpc_d   = redirect_pc & ~32'h3;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control registers: async reset back to BOOT with an empty queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            fpc_q   <= RESET_PC & ~32'h3;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: capture {fpc, imem_rd} at the tail on each push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[tail_q]   <= fpc_q;
            data_mem_q[tail_q] <= imem_rd;
        end
    end

    // Outputs: head entry is presented directly; no empty-queue bypass.
    always_comb begin
        imem_a      = fpc_q[12:2];
        instr_valid = (count_q != '0);
        instr       = data_mem_q[head_q];
        instr_pc    = pc_mem_q[head_q];
        count       = count_q;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: imem returns 0x1000_0000 + word address,
// a scoreboard queue holds the expected (instr, pc) stream for each fetch run
// and is popped on every decode handshake.
module tb_ifetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [10:0]    imem_a;
    logic [31:0]    imem_rd;
    logic           redirect;
    logic [31:0]    redirect_pc;
    logic           instr_valid;
    logic [31:0]    instr;
    logic [31:0]    instr_pc;
    logic           instr_ready;
    logic [CW-1:0]  count;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Instruction memory model: word n holds 0x1000_0000 + n.
    assign imem_rd = 32'h1000_0000 + 32'(imem_a);

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Load the expected stream of n sequential fetches starting at start_pc.
    task automatic sb_load(input logic [31:0] start_pc, input int n);
        logic [31:0] pc;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            pc = start_pc + 32'(4 * i);
            sb.push_back('{instr: 32'h1000_0000 + 32'(pc[12:2]), pc: pc});
        end
    endtask

    // Check any handshake in the current cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow_pc", instr_pc, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                chk("pop_instr", instr, e.instr);
                chk("pop_pc", instr_pc, e.pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_imem_a", 32'(imem_a), 32'd0);
        tick();

        // Release with ready held: valid two cycles later, then no gaps
        reset = 1'b0;
        sb_load(32'h0, 64);
        chk("boot_valid0", 32'(instr_valid), 32'd0);
        tick();
        chk("boot_valid1", 32'(instr_valid), 32'd0);
        chk("boot_count", 32'(count), 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_count", 32'(count), 32'd1);
            tick();
        end

        // Fill with ready low: count 1..4 then holds; imem_a freezes
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        instr_ready = 1'b0;
        sb_load(32'h0, 64);
        chk("fill_count0", 32'(count), 32'd0);
        tick();
        chk("fill_count_boot", 32'(count), 32'd0);
        chk("fill_imem_a0", 32'(imem_a), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("fill_count", 32'(count), 32'(k));
        end
        tick();
        chk("full_count_hold", 32'(count), 32'd4);
        chk("full_imem_a", 32'(imem_a), 32'd4);

        // One-cycle ready pulse at full: push and pop together
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_head_pc", instr_pc, 32'h4);
        chk("pp_imem_a", 32'(imem_a), 32'd5);
        tick();
        chk("pp_hold_count", 32'(count), 32'd4);
        chk("pp_hold_imem_a", 32'(imem_a), 32'd5);

        // Drain at full rate: count stays at DEPTH, order preserved
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("full_stream_count", 32'(count), 32'd4);
            tick();
        end

        // Redirect coinciding with a pop: pop completes, then queue empties
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        sb_load(32'h0000_0200, 64);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_imem_a", 32'(imem_a), 32'h80);
        tick();
        chk("redir_valid1", 32'(instr_valid), 32'd1);
        chk("redir_head_pc", instr_pc, 32'h0000_0200);
        chk("redir_head_instr", instr, 32'h1000_0080);
        for (int i = 0; i < 4; i++) tick();

        // Redirect near the top of the address space: fpc wraps to 0
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        sb_load(32'hFFFF_FFF8, 16);
        chk("wrap_imem_a0", 32'(imem_a), 32'h7FE);
        tick();
        chk("wrap_imem_a1", 32'(imem_a), 32'h7FF);
        tick();
        chk("wrap_imem_a2", 32'(imem_a), 32'h000);
        chk("wrap_count", 32'(count), 32'd2);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Asynchronous reset mid-cycle with three entries queued
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_arst_count", 32'(count), 32'd3);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_pc", instr_pc, 32'd0);
        chk("arst_imem_a", 32'(imem_a), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_ready = 1'b1;
        sb_load(32'h0, 16);
        chk("arst_boot_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("arst_run_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("arst_first_valid", 32'(instr_valid), 32'd1);
        chk("arst_first_pc", instr_pc, 32'h0);
        for (int i = 0; i < 3; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
